// File: rtl/fabric_job_scheduler_if.sv
// Job descriptor push channel and fabric config/start/done handshake.
// The host/fabric side (master) drives descriptors and done; the scheduler (slave) drives the rest.
interface fabric_job_scheduler_if #(
  parameter int ADDR_WIDTH = 32
);
  logic                  job_valid;
  logic                  job_ready;
  logic [ADDR_WIDTH-1:0] job_base_addr;
  logic [15:0]           job_depth;
  logic [7:0]            job_stride;
  logic [31:0]           job_exec_hints;
  logic [15:0]           job_lane_count;
  logic [14:0]           job_lane_mask;

  logic [ADDR_WIDTH-1:0] fabric_base_addr;
  logic [15:0]           fabric_depth;
  logic [7:0]            fabric_stride;
  logic [31:0]           fabric_exec_hints;
  logic [15:0]           fabric_lane_count;
  logic [14:0]           fabric_lane_mask;
  logic                  fabric_start;
  logic                  fabric_done;

  modport master (
    output job_valid, job_base_addr, job_depth, job_stride, job_exec_hints,
           job_lane_count, job_lane_mask, fabric_done,
    input  job_ready, fabric_base_addr, fabric_depth, fabric_stride,
           fabric_exec_hints, fabric_lane_count, fabric_lane_mask, fabric_start
  );

  modport slave (
    input  job_valid, job_base_addr, job_depth, job_stride, job_exec_hints,
           job_lane_count, job_lane_mask, fabric_done,
    output job_ready, fabric_base_addr, fabric_depth, fabric_stride,
           fabric_exec_hints, fabric_lane_count, fabric_lane_mask, fabric_start
  );
endinterface

// File: rtl/fabric_job_scheduler.sv
// Descriptor queue plus launch sequencer for the ternary fabric: one job at a time,
// with watchdog, abort flush and completion/timeout counters.
module fabric_job_scheduler #(
  parameter int ADDR_WIDTH     = 32,
  parameter int QUEUE_DEPTH    = 4,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic                               s_axi_aclk,
  input  logic                               s_axi_aresetn,
  fabric_job_scheduler_if.slave              jif,
  input  logic                               sched_enable,
  input  logic                               abort,
  output logic [$clog2(QUEUE_DEPTH+1)-1:0]   queue_level,
  output logic                               busy,
  output logic [31:0]                        jobs_completed,
  output logic [15:0]                        jobs_timed_out,
  output logic                               irq_done,
  output logic                               irq_timeout
);

  // state   | meaning
  // IDLE    | waiting for enable and a queued descriptor
  // LOAD    | config registered, one settle cycle before start
  // RUN     | fabric_start high, watchdog counting
  // RELEASE | start dropped, waiting for fabric_done to clear
  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_RUN, S_RELEASE} state_e;

  localparam int PTR_W  = $clog2(QUEUE_DEPTH);
  localparam int LVL_W  = $clog2(QUEUE_DEPTH+1);
  localparam int DESC_W = ADDR_WIDTH + 16 + 8 + 32 + 16 + 15;
  localparam int WD_W   = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [WD_W-1:0]  WD_LAST = WD_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
  localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(QUEUE_DEPTH);
  localparam logic [DESC_W-1:0] CFG_RESET = {{ADDR_WIDTH{1'b0}}, 16'd0, 8'd0, 32'd0, 16'd15, 15'h7FFF};

  state_e              state_q, state_d;
  logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0]    level_q, level_d;
  logic [DESC_W-1:0]   mem_q [QUEUE_DEPTH];
  logic [DESC_W-1:0]   cfg_q, cfg_d;
  logic                start_q, start_d;
  logic [WD_W-1:0]     wd_q, wd_d;
  logic [31:0]         comp_q, comp_d;
  logic [15:0]         tmo_q, tmo_d;
  logic                irq_done_q, irq_done_d;
  logic                irq_tmo_q, irq_tmo_d;
  logic                push, pop;
  logic [DESC_W-1:0]   desc_in;

  assign desc_in = {jif.job_base_addr, jif.job_depth, jif.job_stride, jif.job_exec_hints,
                    jif.job_lane_count, jif.job_lane_mask};

  // A full queue refuses a push even when a pop frees a slot in the same cycle.
  assign jif.job_ready = (level_q != LVL_FULL) && !abort;
  assign push          = jif.job_valid && jif.job_ready;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (abort) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      if (push && !pop)      level_d = level_q + LVL_W'(1);
      else if (pop && !push) level_d = level_q - LVL_W'(1);
    end
  end

  always_comb begin
    state_d    = state_q;
    cfg_d      = cfg_q;
    start_d    = start_q;
    wd_d       = wd_q;
    comp_d     = comp_q;
    tmo_d      = tmo_q;
    irq_done_d = 1'b0;
    irq_tmo_d  = 1'b0;
    pop        = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (sched_enable && (level_q != '0) && !abort) begin
          pop     = 1'b1;
          cfg_d   = mem_q[rd_ptr_q];
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        if (abort) begin
          start_d = 1'b0;
          state_d = S_RELEASE;
        end else begin
          start_d = 1'b1;
          wd_d    = '0;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        if (abort) begin
          start_d = 1'b0;
          state_d = S_RELEASE;
        end else if (jif.fabric_done) begin
          start_d    = 1'b0;
          comp_d     = comp_q + 32'd1;
          irq_done_d = 1'b1;
          state_d    = S_RELEASE;
        end else if ((TIMEOUT_CYCLES != 0) && (wd_q == WD_LAST)) begin
          start_d   = 1'b0;
          tmo_d     = tmo_q + 16'd1;
          irq_tmo_d = 1'b1;
          state_d   = S_RELEASE;
        end else begin
          wd_d = wd_q + WD_W'(1);
        end
      end
      S_RELEASE: begin
        if (!jif.fabric_done) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) begin
      state_q    <= S_IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      cfg_q      <= CFG_RESET;
      start_q    <= 1'b0;
      wd_q       <= '0;
      comp_q     <= '0;
      tmo_q      <= '0;
      irq_done_q <= 1'b0;
      irq_tmo_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      cfg_q      <= cfg_d;
      start_q    <= start_d;
      wd_q       <= wd_d;
      comp_q     <= comp_d;
      tmo_q      <= tmo_d;
      irq_done_q <= irq_done_d;
      irq_tmo_q  <= irq_tmo_d;
    end
  end

  // Descriptor storage needs no reset; the level/pointers define validity.
  always_ff @(posedge s_axi_aclk) begin
    if (push) mem_q[wr_ptr_q] <= desc_in;
  end

  assign {jif.fabric_base_addr, jif.fabric_depth, jif.fabric_stride, jif.fabric_exec_hints,
          jif.fabric_lane_count, jif.fabric_lane_mask} = cfg_q;
  assign jif.fabric_start = start_q;
  assign queue_level      = level_q;
  assign busy             = (state_q != S_IDLE);
  assign jobs_completed   = comp_q;
  assign jobs_timed_out   = tmo_q;
  assign irq_done         = irq_done_q;
  assign irq_timeout      = irq_tmo_q;

endmodule

// File: tb/tb_fabric_job_scheduler.sv
// Randomized bench for fabric_job_scheduler against a queue-based job-lifecycle model.
module tb_fabric_job_scheduler;
  localparam int AW = 32;
  localparam int QD = 4;
  localparam int TO = 20;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        sched_enable, abort;
  logic [2:0]  queue_level;
  logic        busy;
  logic [31:0] jobs_completed;
  logic [15:0] jobs_timed_out;
  logic        irq_done, irq_timeout;

  always #5 clk = ~clk;

  fabric_job_scheduler_if #(.ADDR_WIDTH(AW)) jif ();

  fabric_job_scheduler #(.ADDR_WIDTH(AW), .QUEUE_DEPTH(QD), .TIMEOUT_CYCLES(TO)) dut (
    .s_axi_aclk     (clk),
    .s_axi_aresetn  (rst_n),
    .jif            (jif),
    .sched_enable   (sched_enable),
    .abort          (abort),
    .queue_level    (queue_level),
    .busy           (busy),
    .jobs_completed (jobs_completed),
    .jobs_timed_out (jobs_timed_out),
    .irq_done       (irq_done),
    .irq_timeout    (irq_timeout)
  );

  typedef struct packed {
    logic [31:0] base;
    logic [15:0] depth;
    logic [7:0]  stride;
    logic [31:0] hints;
    logic [15:0] lanes;
    logic [14:0] mask;
  } desc_t;

  desc_t model_q[$];
  int    exp_done_cnt = 0;
  int    exp_tmo_cnt  = 0;
  int    n_checks     = 0;
  int    n_fails      = 0;

  task automatic check_val(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic desc_t rand_desc();
    desc_t d;
    d.base   = $urandom;
    d.depth  = 16'($urandom);
    d.stride = 8'($urandom);
    d.hints  = $urandom;
    d.lanes  = 16'($urandom);
    d.mask   = 15'($urandom);
    return d;
  endfunction

  task automatic drive_desc(input desc_t d);
    jif.job_base_addr  = d.base;
    jif.job_depth      = d.depth;
    jif.job_stride     = d.stride;
    jif.job_exec_hints = d.hints;
    jif.job_lane_count = d.lanes;
    jif.job_lane_mask  = d.mask;
  endtask

  task automatic check_cfg(input string tag, input desc_t e);
    check_val({tag, "_base_hints"}, {jif.fabric_base_addr, jif.fabric_exec_hints}, {e.base, e.hints});
    check_val({tag, "_shape"}, {9'd0, jif.fabric_depth, jif.fabric_stride, jif.fabric_lane_count, jif.fabric_lane_mask},
              {9'd0, e.depth, e.stride, e.lanes, e.mask});
  endtask

  task automatic check_counters(input string tag);
    check_val({tag, "_completed"}, jobs_completed, 32'(exp_done_cnt));
    check_val({tag, "_timed_out"}, jobs_timed_out, 16'(exp_tmo_cnt));
  endtask

  // Push one descriptor; scheduler must not be popping on this edge.
  task automatic push_one(input desc_t d);
    bit exp_rdy;
    exp_rdy = (model_q.size() < QD) && !abort;
    drive_desc(d);
    jif.job_valid = 1'b1;
    #1;
    check_val("push_ready", jif.job_ready, exp_rdy);
    step();
    jif.job_valid = 1'b0;
    if (exp_rdy) model_q.push_back(d);
    check_val("push_level", queue_level, model_q.size());
  endtask

  // Next edge is the launch (pop) edge. done_after: edge index after start rises
  // at which done is sampled high; values above TO mean the fabric never answers.
  task automatic run_one_job(input int done_after, input int hold);
    desc_t e;
    int    hi;
    bit    is_done;
    e = model_q.pop_front();
    step();
    jif.job_valid = 1'b0;
    check_cfg("load_cfg", e);
    check_val("load_level", queue_level, model_q.size());
    check_val("load_start", jif.fabric_start, 0);
    check_val("load_busy", busy, 1);
    step();
    check_val("launch_start", jif.fabric_start, 1);
    hi = 0;
    for (int k = 1; k <= TO + 5; k++) begin
      jif.fabric_done = (k == done_after);
      step();
      hi = k;
      if (!jif.fabric_start) break;
    end
    is_done = (done_after >= 1) && (done_after <= TO);
    check_val("start_high_cycles", hi, is_done ? done_after : TO);
    if (is_done) exp_done_cnt++;
    else         exp_tmo_cnt++;
    check_val("irq_done_pulse", irq_done, is_done);
    check_val("irq_timeout_pulse", irq_timeout, !is_done);
    check_counters("end");
    if (is_done) begin
      for (int h = 0; h < hold; h++) begin
        step();
        check_val("release_busy", busy, 1);
        check_val("release_irq", {irq_done, irq_timeout, jif.fabric_start}, 3'b000);
      end
    end
    jif.fabric_done = 1'b0;
    step();
    check_val("exit_busy", busy, 0);
    check_val("exit_quiet", {irq_done, irq_timeout, jif.fabric_start}, 3'b000);
    check_counters("exit");
  endtask

  desc_t d;
  int    n;

  initial begin
    rst_n         = 1'b0;
    sched_enable  = 1'b0;
    abort         = 1'b0;
    jif.job_valid = 1'b0;
    jif.fabric_done = 1'b0;
    drive_desc('0);
    #12;
    check_val("rst_start", jif.fabric_start, 0);
    check_val("rst_level", queue_level, 0);
    check_val("rst_lanes", jif.fabric_lane_count, 15);
    check_val("rst_mask", jif.fabric_lane_mask, 15'h7FFF);
    check_val("rst_base", jif.fabric_base_addr, 0);
    check_val("rst_busy_irq", {busy, irq_done, irq_timeout}, 3'b000);
    check_counters("rst");
    check_val("rst_ready", jif.job_ready, 1);
    @(negedge clk);
    rst_n = 1'b1;
    step();

    // Single directed job: config one edge after push, start two edges after.
    d = '{base: 32'h1000, depth: 16'd64, stride: 8'd1, hints: 32'd0, lanes: 16'd4, mask: 15'h7FFF};
    sched_enable = 1'b1;
    drive_desc(d);
    jif.job_valid = 1'b1;
    step();
    jif.job_valid = 1'b0;
    model_q.push_back(d);
    check_val("single_level", queue_level, 1);
    check_val("single_start", jif.fabric_start, 0);
    run_one_job(10, 0);

    // Fill with scheduling disabled: fifth push refused.
    sched_enable = 1'b0;
    for (int i = 0; i < 5; i++) push_one(rand_desc());
    check_val("fill_level", queue_level, QD);
    // Enable while pushing into a full queue: pop happens, push still refused.
    drive_desc(rand_desc());
    jif.job_valid = 1'b1;
    sched_enable  = 1'b1;
    #1;
    check_val("full_pop_ready", jif.job_ready, 0);
    run_one_job($urandom_range(1, TO - 1), $urandom_range(0, 2));
    run_one_job(TO, 0);
    run_one_job(TO + 5, 0);
    run_one_job($urandom_range(1, TO - 1), $urandom_range(0, 2));
    repeat (3) step();
    check_val("drained_idle", {busy, jif.fabric_start}, 2'b00);
    check_val("drained_level", queue_level, 0);

    // Randomized batches.
    for (int b = 0; b < 6; b++) begin
      sched_enable = 1'b0;
      n = $urandom_range(1, 5);
      for (int i = 0; i < n; i++) push_one(rand_desc());
      sched_enable = 1'b1;
      while (model_q.size() > 0) begin
        run_one_job($urandom_range(1, TO + 4), $urandom_range(0, 2));
        if (model_q.size() > 0 && $urandom_range(0, 2) == 0) begin
          sched_enable = 1'b0;
          repeat (3) step();
          check_val("hold_off_idle", {busy, jif.fabric_start}, 2'b00);
          check_val("hold_off_level", queue_level, model_q.size());
          sched_enable = 1'b1;
        end
      end
    end

    // Abort with one job running and three queued.
    sched_enable = 1'b0;
    for (int i = 0; i < 4; i++) push_one(rand_desc());
    sched_enable = 1'b1;
    d = model_q.pop_front();
    step();
    check_cfg("abort_load", d);
    step();
    check_val("abort_run_start", jif.fabric_start, 1);
    check_val("abort_run_level", queue_level, 3);
    repeat (3) step();
    abort = 1'b1;
    drive_desc(rand_desc());
    jif.job_valid = 1'b1;
    #1;
    check_val("abort_ready", jif.job_ready, 0);
    step();
    abort = 1'b0;
    jif.job_valid = 1'b0;
    model_q.delete();
    check_val("abort_start", jif.fabric_start, 0);
    check_val("abort_level", queue_level, 0);
    check_val("abort_irq", {irq_done, irq_timeout}, 2'b00);
    check_counters("abort");
    check_val("abort_busy", busy, 1);
    jif.fabric_done = 1'b1;
    repeat (2) begin
      step();
      check_val("abort_hold_busy", busy, 1);
      check_val("abort_hold_irq", {irq_done, irq_timeout}, 2'b00);
    end
    check_counters("abort_hold");
    jif.fabric_done = 1'b0;
    step();
    check_val("abort_exit_busy", busy, 0);
    repeat (3) step();
    check_val("abort_no_launch", {busy, jif.fabric_start}, 2'b00);

    // Asynchronous reset in the middle of a running job.
    sched_enable = 1'b0;
    for (int i = 0; i < 3; i++) push_one(rand_desc());
    sched_enable = 1'b1;
    step();
    step();
    check_val("prerst_start", jif.fabric_start, 1);
    #3;
    rst_n = 1'b0;
    #1;
    check_val("async_rst_start", jif.fabric_start, 0);
    check_val("async_rst_level", queue_level, 0);
    check_val("async_rst_lanes", jif.fabric_lane_count, 15);
    check_val("async_rst_mask", jif.fabric_lane_mask, 15'h7FFF);
    check_val("async_rst_busy", busy, 0);
    check_val("async_rst_counters", {jobs_completed, jobs_timed_out}, 48'd0);
    @(negedge clk);
    rst_n = 1'b1;
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1);
  end
endmodule
